// File: rtl/z80_mem_bridge.sv
// Bridges the Z80 wrapper bus to a single-port req/ack memory, stretching CPU cycles with wait_n.
// Optional macro Z80_BRIDGE_IO_EN forwards I/O cycles to the memory side (mem_io=1).
`timescale 1ns/1ps

module z80_mem_bridge #(
    parameter int          ADDR_W  = 16,
    parameter logic [7:0]  INT_VEC = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       A,
    input  logic [7:0]        dout,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfsh_n,
    output logic              wait_n,
    output logic [7:0]        din,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_io,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_next;

    logic io_cyc;
    logic cyc;
    logic inta;
    logic fwd;

    assign io_cyc = ~iorq_n & m1_n;
    assign cyc    = rfsh_n & (~mreq_n | io_cyc) & (~rd_n | ~wr_n);
    assign inta   = ~m1_n & ~iorq_n;

    // fwd marks cycles that must be served by the memory side.
`ifdef Z80_BRIDGE_IO_EN
    assign fwd = cyc;
`else
    assign fwd = cyc & ~io_cyc;
    assign mem_io = 1'b0;
`endif

    assign wait_n = reset | ~(fwd & (state != DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fwd)     state_next = REQ;
            REQ:     if (mem_ack) state_next = DONE;
            DONE:    if (!cyc)    state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Request fields are latched once in IDLE and stay frozen until the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
`ifdef Z80_BRIDGE_IO_EN
            mem_io    <= 1'b0;
`endif
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            din       <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    if (fwd) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ~wr_n;
`ifdef Z80_BRIDGE_IO_EN
                        mem_io    <= io_cyc;
`endif
                        mem_addr  <= ADDR_W'(A);
                        mem_wdata <= dout;
                    end else if (inta && rfsh_n) begin
                        din <= INT_VEC;
                    end
`ifndef Z80_BRIDGE_IO_EN
                    else if (cyc && io_cyc && !rd_n) begin
                        din <= 8'hFF;
                    end
`endif
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            din <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Directed self-checking bench for z80_mem_bridge with a small ack-latency memory responder.
`timescale 1ns/1ps

module tb_z80_mem_bridge;

    localparam logic [5:0] BUS_IDLE = 6'b111111;   // {m1_n,mreq_n,iorq_n,rd_n,wr_n,rfsh_n}
    localparam logic [5:0] MEM_RD   = 6'b101011;
    localparam logic [5:0] MEM_WR   = 6'b101101;
    localparam logic [5:0] RFSH_RD  = 6'b101010;
    localparam logic [5:0] INTA_CYC = 6'b010111;
    localparam logic [5:0] IO_RD    = 6'b110011;
    localparam logic [5:0] IO_WR    = 6'b110101;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic        wait_n;
    logic [7:0]  din;
    logic        mem_req, mem_we, mem_io;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        model_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        ack_en = 1'b1;
    int          ack_lat = 1;
    int          req_cnt_cyc = 0;
    int          req_count = 0;
    int          unstable = 0;
    logic [15:0] seen_addr;
    logic        seen_we, seen_io;
    logic [7:0]  seen_wdata;

    int total = 0;
    int bad = 0;

    assign mem_ack = model_ack | stray_ack;

    z80_mem_bridge #(.ADDR_W(16), .INT_VEC(8'hFF)) dut (
        .clk(clk), .reset(reset), .A(A), .dout(dout),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .wait_n(wait_n), .din(din),
        .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Acks the ack_lat-th rising edge after mem_req rises; records and watches request fields.
    always @(negedge clk) begin
        if (mem_req) begin
            if (req_cnt_cyc == 0) begin
                req_count++;
                seen_addr  = mem_addr;
                seen_we    = mem_we;
                seen_io    = mem_io;
                seen_wdata = mem_wdata;
            end else if (mem_addr != seen_addr || mem_we != seen_we ||
                         mem_io != seen_io || mem_wdata != seen_wdata) begin
                unstable++;
            end
            req_cnt_cyc++;
            model_ack = ack_en && (req_cnt_cyc == ack_lat);
        end else begin
            req_cnt_cyc = 0;
            model_ack   = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] ctl, input logic [15:0] addr, input logic [7:0] data);
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = ctl;
        A    = addr;
        dout = data;
    endtask

    // Runs one CPU cycle; waits = edges that saw wait_n low, reqs = memory requests issued.
    task automatic busCycle(input logic [5:0] ctl, input logic [15:0] addr, input logic [7:0] data,
                            input int lat, input logic [7:0] rdata, output int waits, output int reqs);
        ack_lat   = lat;
        mem_rdata = rdata;
        req_count = 0;
        waits     = 0;
        @(negedge clk);
        applyStimulus(ctl, addr, data);
        for (int k = 0; k < 30; k++) begin
            #1;
            if (wait_n) break;
            waits++;
            @(negedge clk);
        end
        @(negedge clk);
        applyStimulus(BUS_IDLE, 16'h0000, 8'h00);
        repeat (2) @(negedge clk);
        reqs = req_count;
    endtask

    initial begin
        int waits, reqs;
        reset     = 1'b1;
        mem_rdata = 8'h00;
        applyStimulus(BUS_IDLE, 16'h0000, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_wait_n", wait_n, 1);
        checkOutput("rst_din", din, 8'hFF);
        checkOutput("rst_mem_req", mem_req, 0);
        @(negedge clk);
        reset = 1'b0;

        // Read with ack on the third edge after mem_req rises.
        busCycle(MEM_RD, 16'h1234, 8'h00, 3, 8'h5A, waits, reqs);
        checkOutput("rd_waits", waits, 4);
        checkOutput("rd_reqs", reqs, 1);
        checkOutput("rd_addr", seen_addr, 16'h1234);
        checkOutput("rd_we", seen_we, 0);
        checkOutput("rd_din", din, 8'h5A);
        checkOutput("rd_stable", unstable, 0);

        // Write acked in the first mem_req cycle: one extra wait edge beyond the first.
        busCycle(MEM_WR, 16'hBEEF, 8'hC3, 1, 8'h11, waits, reqs);
        checkOutput("wr_waits", waits, 2);
        checkOutput("wr_reqs", reqs, 1);
        checkOutput("wr_we", seen_we, 1);
        checkOutput("wr_addr", seen_addr, 16'hBEEF);
        checkOutput("wr_wdata", seen_wdata, 8'hC3);
        checkOutput("wr_din", din, 8'h5A);

        busCycle(RFSH_RD, 16'h0042, 8'h00, 1, 8'h22, waits, reqs);
        checkOutput("rfsh_waits", waits, 0);
        checkOutput("rfsh_reqs", reqs, 0);

        busCycle(INTA_CYC, 16'h0000, 8'h00, 1, 8'h33, waits, reqs);
        checkOutput("inta_waits", waits, 0);
        checkOutput("inta_reqs", reqs, 0);
        checkOutput("inta_din", din, 8'hFF);

        busCycle(MEM_RD, 16'h4000, 8'h00, 2, 8'h96, waits, reqs);
        checkOutput("rd2_waits", waits, 3);
        checkOutput("rd2_din", din, 8'h96);

        // Reset pulse in the middle of a long request, then a stray ack.
        ack_en    = 1'b0;
        req_count = 0;
        @(negedge clk);
        applyStimulus(MEM_RD, 16'h5555, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("pre_rst_req", mem_req, 1);
        reset = 1'b1;
        applyStimulus(BUS_IDLE, 16'h0000, 8'h00);
        #1;
        checkOutput("mid_rst_wait_n", wait_n, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_req", mem_req, 0);
        checkOutput("post_rst_din", din, 8'hFF);
        checkOutput("post_rst_addr", mem_addr, 16'h0000);
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        #1;
        checkOutput("stray_req", mem_req, 0);
        checkOutput("stray_din", din, 8'hFF);
        checkOutput("stray_wait_n", wait_n, 1);
        checkOutput("stray_reqs", req_count, 1);
        ack_en = 1'b1;

        busCycle(MEM_RD, 16'h0100, 8'h00, 1, 8'h3C, waits, reqs);
        checkOutput("rd3_din", din, 8'h3C);

        busCycle(IO_RD, 16'h00FE, 8'h00, 2, 8'h77, waits, reqs);
`ifdef Z80_BRIDGE_IO_EN
        checkOutput("io_rd_reqs", reqs, 1);
        checkOutput("io_rd_io", seen_io, 1);
        checkOutput("io_rd_addr", seen_addr, 16'h00FE);
        checkOutput("io_rd_din", din, 8'h77);
`else
        checkOutput("io_rd_reqs", reqs, 0);
        checkOutput("io_rd_waits", waits, 0);
        checkOutput("io_rd_din", din, 8'hFF);
        checkOutput("io_rd_mem_io", mem_io, 0);
`endif

        busCycle(IO_WR, 16'h0010, 8'hA5, 1, 8'h00, waits, reqs);
`ifdef Z80_BRIDGE_IO_EN
        checkOutput("io_wr_reqs", reqs, 1);
        checkOutput("io_wr_we", seen_we, 1);
        checkOutput("io_wr_wdata", seen_wdata, 8'hA5);
`else
        checkOutput("io_wr_reqs", reqs, 0);
        checkOutput("io_wr_waits", waits, 0);
        checkOutput("io_wr_din", din, 8'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
